mem_gpio_responder: RTL and testbench



---
 rtl/mem_gpio_responder_pkg.sv | 40 ++++
 rtl/mem_gpio_responder_gpio_bank.sv | 65 ++++++
 rtl/mem_gpio_responder.sv | 83 ++++++++
 tb/tb_mem_gpio_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_gpio_responder_pkg.sv
// Shared memory-map constants and store-strobe helpers for the core/RAM/GPIO bus.
package mem_gpio_responder_pkg;

  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_BYTE = 3'b100;
  localparam logic [2:0] WE_HALF = 3'b010;
  localparam logic [2:0] WE_WORD = 3'b001;

  localparam logic [3:0] GPIO_OUT_OFS = 4'h0;
  localparam logic [3:0] GPIO_DIR_OFS = 4'h4;
  localparam logic [3:0] GPIO_IN_OFS  = 4'h8;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Encoding matches addr[3:2] within the GPIO block.
  typedef enum logic [1:0] {RegOut, RegDir, RegIn, RegNone} gpio_reg_e;

  function automatic logic we_legal(input logic [2:0] we);
    return (we == WE_NONE) || (we == WE_BYTE) || (we == WE_HALF) || (we == WE_WORD);
  endfunction

  function automatic logic [3:0] we_lanes(input logic [2:0] we, input logic [1:0] ofs);
    case (we)
      WE_BYTE: return 4'b0001 << ofs;
      WE_HALF: return ofs[1] ? 4'b1100 : 4'b0011;
      WE_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data so every enabled lane sees its bytes.
  function automatic logic [31:0] we_wdata(input logic [2:0] we, input logic [31:0] d);
    case (we)
      WE_BYTE: return {4{d[7:0]}};
      WE_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_gpio_responder_gpio_bank.sv
// GPIO bank: OUT/DIR registers, tri-state pin drive, 2-flop input synchronizer, read mux.
module mem_gpio_responder_gpio_bank
  import mem_gpio_responder_pkg::*;
#(
  parameter int unsigned GpioWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en_i,
  input  logic                 wr_word_i,
  input  gpio_reg_e            reg_sel_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o,
  inout  wire  [GpioWidth-1:0] gpio_io
);

  logic [GpioWidth-1:0] out_q, out_d, dir_q, dir_d, sync1_q, sync2_q;
  logic [31:0]          out_w, dir_w, in_w, wmask;

  always_comb begin
    out_w = '0;
    dir_w = '0;
    in_w  = '0;
    out_w[GpioWidth-1:0] = out_q;
    dir_w[GpioWidth-1:0] = dir_q;
    in_w[GpioWidth-1:0]  = sync2_q;
    // Sub-word stores only reach the low byte of a register.
    wmask = wr_word_i ? 32'hFFFF_FFFF : 32'h0000_00FF;
    out_d = out_q;
    dir_d = dir_q;
    if (wr_en_i) begin
      if (reg_sel_i == RegOut) out_d = GpioWidth'((out_w & ~wmask) | (wdata_i & wmask));
      if (reg_sel_i == RegDir) dir_d = GpioWidth'((dir_w & ~wmask) | (wdata_i & wmask));
    end
  end

  always_comb begin
    rdata_o = '0;
    unique case (reg_sel_i)
      RegOut:  rdata_o = out_w;
      RegDir:  rdata_o = dir_w;
      RegIn:   rdata_o = in_w;
      RegNone: rdata_o = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      dir_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      sync1_q <= gpio_io;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < GpioWidth; i++) begin : g_pin
    assign gpio_io[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

endmodule

// File: rtl/mem_gpio_responder.sv
// Memory-side responder: word RAM with byte/half/word stores, GPIO decode, illegal-access flag.
module mem_gpio_responder
  import mem_gpio_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned GPIO_WIDTH = 8,
  parameter logic [31:0] GPIO_BASE  = 32'h0001_0000,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           iaddr,
  output logic [31:0]           inst,
  input  logic [2:0]            write_enable,
  input  logic [31:0]           addr,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  bad_access,
  inout  wire  [GPIO_WIDTH-1:0] gpio
);

  localparam int unsigned IdxW     = $clog2(MEM_WORDS);
  localparam logic [31:0] RamBytes = 32'(MEM_WORDS) << 2;

  logic [31:0]     mem_q [MEM_WORDS];
  logic [IdxW-1:0] d_idx, i_idx;
  logic            d_in_ram, d_in_gpio, i_in_ram;
  logic            we_ok, store, ram_we, gpio_we;
  logic [3:0]      lanes;
  logic [31:0]     wdata, gpio_rdata, rd_word;
  logic            bad_q, bad_d;

  always_comb begin
    d_in_ram  = addr < RamBytes;
    d_in_gpio = addr[31:4] == GPIO_BASE[31:4];
    i_in_ram  = iaddr < RamBytes;
    d_idx     = addr[IdxW+1:2];
    i_idx     = iaddr[IdxW+1:2];
    we_ok     = we_legal(write_enable);
    store     = we_ok && (write_enable != WE_NONE);
    ram_we    = store && d_in_ram;
    gpio_we   = store && d_in_gpio;
    lanes     = we_lanes(write_enable, addr[1:0]);
    wdata     = we_wdata(write_enable, data_in);
    bad_d     = !we_ok || (store && !d_in_ram && !d_in_gpio) || !i_in_ram;

    inst = i_in_ram ? mem_q[i_idx] : NOP_INST;
    if (d_in_ram)       rd_word = mem_q[d_idx];
    else if (d_in_gpio) rd_word = gpio_rdata;
    else                rd_word = '0;
    data_out = rd_word >> {addr[1:0], 3'b000};
  end

  // RAM is intentionally never reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes[b]) mem_q[d_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bad_q <= 1'b0;
    else        bad_q <= bad_d;
  end

  assign bad_access = bad_q;

  mem_gpio_responder_gpio_bank #(
    .GpioWidth(GPIO_WIDTH)
  ) u_gpio_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (gpio_we),
    .wr_word_i(write_enable == WE_WORD),
    .reg_sel_i(gpio_reg_e'(addr[3:2])),
    .wdata_i  (data_in),
    .rdata_o  (gpio_rdata),
    .gpio_io  (gpio)
  );

endmodule

// File: tb/tb_mem_gpio_responder.sv
// Scoreboard bench: stimulus queues expected values, a negedge monitor pops and compares.
module tb_mem_gpio_responder;
  import mem_gpio_responder_pkg::*;

  localparam int unsigned GW   = 8;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [31:0] RAMB = 32'd4096;

  localparam int unsigned SelData = 0;
  localparam int unsigned SelInst = 1;
  localparam int unsigned SelBad  = 2;
  localparam int unsigned SelPins = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   iaddr = '0;
  logic [31:0]   inst;
  logic [2:0]    write_enable = '0;
  logic [31:0]   addr = '0;
  logic [31:0]   data_in = '0;
  logic [31:0]   data_out;
  logic          bad_access;
  wire  [GW-1:0] gpio;
  logic [GW-1:0] tb_en = '0;
  logic [GW-1:0] tb_val = '0;

  for (genvar i = 0; i < GW; i++) begin : g_drv
    assign gpio[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  always #5 clk = ~clk;

  mem_gpio_responder #(
    .MEM_WORDS (1024),
    .GPIO_WIDTH(GW),
    .GPIO_BASE (BASE),
    .INIT_FILE ("")
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iaddr       (iaddr),
    .inst        (inst),
    .write_enable(write_enable),
    .addr        (addr),
    .data_in     (data_in),
    .data_out    (data_out),
    .bad_access  (bad_access),
    .gpio        (gpio)
  );

  typedef struct {
    string       name;
    int unsigned sel;
    logic [31:0] exp;
    logic [31:0] mask;
  } chk_t;

  chk_t        sb_q[$];
  chk_t        cur;
  logic [31:0] act;
  int          checks = 0;
  int          failures = 0;

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      cur = sb_q.pop_front();
      case (cur.sel)
        SelData: act = data_out;
        SelInst: act = inst;
        SelBad:  act = {31'b0, bad_access};
        default: act = 32'(gpio);
      endcase
      checks++;
      if ((act & cur.mask) !== (cur.exp & cur.mask)) begin
        failures++;
        $display("FAIL %s: got %h expected %h (mask %h)", cur.name, act, cur.exp, cur.mask);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string n, input int unsigned s, input logic [31:0] e,
                            input logic [31:0] m = 32'hFFFF_FFFF);
    chk_t c;
    c.name = n;
    c.sel  = s;
    c.exp  = e;
    c.mask = m;
    sb_q.push_back(c);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d checks left, required 0", sb_q.size());
      sb_q.delete();
    end
    #1;
  endtask

  task automatic store(input logic [2:0] we, input logic [31:0] a, input logic [31:0] d);
    write_enable = we;
    addr         = a;
    data_in      = d;
    cyc();
    write_enable = WE_NONE;
  endtask

  task automatic read_chk(input string n, input logic [31:0] a, input logic [31:0] e);
    addr = a;
    expect_val(n, SelData, e);
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc();
    expect_val("bad_in_reset", SelBad, 32'h0);
    drain();
    rst_n = 1'b1;
    read_chk("out_reset", BASE + 32'h0, 32'h0);
    read_chk("dir_reset", BASE + 32'h4, 32'h0);
    tb_en  = 8'hFF;
    tb_val = 8'hA5;
    cyc(); cyc();
    read_chk("pins_released_at_reset", BASE + 32'h8, 32'h0000_00A5);
    tb_en = '0;

    // Word store, word and byte reads
    store(WE_WORD, 32'h10, 32'hDEAD_BEEF);
    read_chk("sw_read", 32'h10, 32'hDEAD_BEEF);
    read_chk("lb_0x13", 32'h13, 32'h0000_00DE);

    // Byte and halfword lane merge
    store(WE_WORD, 32'h20, 32'h1122_3344);
    store(WE_BYTE, 32'h21, 32'h0000_00AA);
    read_chk("sb_merge", 32'h20, 32'h1122_AA44);
    store(WE_HALF, 32'h22, 32'h0000_5566);
    read_chk("sh_merge", 32'h20, 32'h5566_AA44);
    read_chk("lh_0x22", 32'h22, 32'h0000_5566);
    read_chk("shift_0x21", 32'h21, 32'h0055_66AA);

    // Illegal strobe: no write, one-cycle pulse
    store(3'b011, 32'h20, 32'hFFFF_FFFF);
    addr = 32'h20;
    expect_val("bad_we_pulse", SelBad, 32'h1);
    expect_val("bad_we_clear", SelBad, 32'h0);
    expect_val("bad_we_nowrite", SelData, 32'h5566_AA44);
    drain();

    // GPIO drive and input sampling latency
    store(WE_WORD, BASE + 32'h4, 32'h0000_000F);
    store(WE_WORD, BASE + 32'h0, 32'h0000_0005);
    addr = BASE + 32'h4;
    expect_val("pins_out", SelPins, 32'h0000_0005, 32'h0000_000F);
    expect_val("dir_read", SelData, 32'h0000_000F);
    drain();
    addr   = BASE + 32'h8;
    tb_en  = 8'h10;
    tb_val = 8'h10;
    expect_val("in4_edge0", SelData, 32'h0, 32'h0000_0010);
    expect_val("in4_edge1", SelData, 32'h0, 32'h0000_0010);
    expect_val("in4_edge2", SelData, 32'h0000_0015, 32'h0000_001F);
    drain();
    read_chk("gpio_reserved", BASE + 32'hC, 32'h0);
    tb_en = '0;

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    rst_n  = 1'b0;
    tb_en  = 8'h0F;
    tb_val = 8'h0A;
    addr   = BASE + 32'h4;
    expect_val("pins_z_async_reset", SelPins, 32'h0000_000A, 32'h0000_000F);
    expect_val("dir_async_reset", SelData, 32'h0);
    drain();
    rst_n = 1'b1;
    tb_en = '0;
    read_chk("out_after_reset", BASE + 32'h0, 32'h0);
    read_chk("dir_after_reset", BASE + 32'h4, 32'h0);
    read_chk("ram_survives_reset", 32'h10, 32'hDEAD_BEEF);

    // Simultaneous fetch and store to the same word
    store(WE_WORD, 32'h30, 32'h0102_0304);
    iaddr        = 32'h30;
    write_enable = WE_WORD;
    addr         = 32'h30;
    data_in      = 32'hCAFE_F00D;
    expect_val("fetch_old", SelInst, 32'h0102_0304);
    cyc();
    write_enable = WE_NONE;
    expect_val("fetch_new", SelInst, 32'hCAFE_F00D);
    drain();

    // Fetch outside RAM
    iaddr = RAMB;
    expect_val("fetch_oob_nop", SelInst, NOP_INST);
    cyc();
    iaddr = 32'h30;
    expect_val("fetch_oob_pulse", SelBad, 32'h1);
    expect_val("fetch_oob_clear", SelBad, 32'h0);
    drain();

    // Store outside both regions: dropped, no aliasing onto word 4
    store(WE_WORD, 32'h4, 32'h5A5A_5A5A);
    store(WE_WORD, RAMB + 32'h4, 32'hFFFF_FFFF);
    addr = 32'h4;
    expect_val("store_oob_pulse", SelBad, 32'h1);
    expect_val("store_oob_clear", SelBad, 32'h0);
    expect_val("store_oob_noalias", SelData, 32'h5A5A_5A5A);
    drain();

    // Data read outside both regions: zero, no flag
    addr = 32'h0000_8000;
    expect_val("read_oob_zero", SelData, 32'h0);
    expect_val("read_oob_noflag0", SelBad, 32'h0);
    expect_val("read_oob_noflag1", SelBad, 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
